// File: rtl/norm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | norm_pkg: shared types and constants for the DW_norm rounding stage  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package norm_pkg;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RTZ = 2'b01,
        RM_RUP = 2'b10,
        RM_RDN = 2'b11
    } round_mode_e;

    typedef struct packed {
        logic zero;
        logic ovfl;
        logic inexact;
    } norm_flags_t;

    // Output register occupancy, encoded directly as {m_valid, s_valid}.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } skid_state_e;

    // All-ones saturation pattern; users slice it to their exponent width.
    localparam logic [31:0] c_exp_sat = 32'hFFFF_FFFF;

endpackage : norm_pkg
`default_nettype wire

// File: rtl/norm_rne_round.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | norm_rne_round: combinational RNE rounding with exponent saturation  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module norm_rne_round
    import norm_pkg::*;
#(
    parameter int A_WIDTH   = 8,
    parameter int EXP_WIDTH = 4,
    parameter int OUT_WIDTH = 5
) (
    input  logic [A_WIDTH-1:0]   i_b,
    input  logic [EXP_WIDTH-1:0] i_exp,
    input  logic                 i_no_detect,
    input  logic                 i_ovfl,
    output logic [OUT_WIDTH-1:0] o_m,
    output logic [EXP_WIDTH-1:0] o_exp,
    output norm_flags_t          o_flags
);

    localparam int c_guard_pos = A_WIDTH - OUT_WIDTH - 1;
    localparam logic [EXP_WIDTH-1:0] c_exp_max = c_exp_sat[EXP_WIDTH-1:0];

    logic [OUT_WIDTH-1:0] w_kept;
    logic                 w_guard;
    logic                 w_sticky;
    logic                 w_round_up;
    logic [OUT_WIDTH:0]   w_sum;
    logic                 w_carry;

    assign w_kept     = i_b[A_WIDTH-1 -: OUT_WIDTH];
    assign w_guard    = i_b[c_guard_pos];
    assign w_sticky   = |i_b[c_guard_pos-1:0];
    assign w_round_up = w_guard & (w_sticky | w_kept[0]);
    assign w_sum      = {1'b0, w_kept} + {{OUT_WIDTH{1'b0}}, w_round_up};
    assign w_carry    = w_sum[OUT_WIDTH];

    always_comb begin
        o_m             = w_sum[OUT_WIDTH-1:0];
        o_exp           = i_exp;
        o_flags.zero    = 1'b0;
        o_flags.ovfl    = 1'b0;
        o_flags.inexact = w_guard | w_sticky;

        if (i_no_detect) begin
            o_m             = '0;
            o_exp           = '0;
            o_flags.zero    = 1'b1;
            o_flags.inexact = |i_b;
        end else if (i_ovfl || (w_carry && (i_exp == c_exp_max))) begin
            o_m          = '1;
            o_exp        = c_exp_max;
            o_flags.ovfl = 1'b1;
        end else if (w_carry) begin
            // Mantissa wrapped to zero; renormalise to 1.000... and bump exponent.
            o_m   = {1'b1, {(OUT_WIDTH-1){1'b0}}};
            o_exp = i_exp + {{(EXP_WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule : norm_rne_round
`default_nettype wire

// File: rtl/norm_round_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | norm_round_pipe: RNE round/pack stage with skid buffer and counter   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module norm_round_pipe
    import norm_pkg::*;
#(
    parameter int A_WIDTH   = 8,
    parameter int EXP_WIDTH = 4,
    parameter int OUT_WIDTH = 5,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_WIDTH-1:0]   in_b,
    input  logic [EXP_WIDTH-1:0] in_exp,
    input  logic                 in_no_detect,
    input  logic                 in_ovfl,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_m,
    output logic [EXP_WIDTH-1:0] out_exp,
    output logic                 out_zero,
    output logic                 out_ovfl,
    output logic                 out_inexact,
    input  logic                 cnt_clr,
    output logic [CNT_WIDTH-1:0] inexact_cnt
);

    localparam int c_res_w = OUT_WIDTH + EXP_WIDTH + 3;

    logic [OUT_WIDTH-1:0] w_rnd_m;
    logic [EXP_WIDTH-1:0] w_rnd_exp;
    norm_flags_t          w_rnd_flags;
    logic [c_res_w-1:0]   w_rnd_res;
    logic                 w_accept;
    logic                 w_drain;
    norm_flags_t          w_out_flags;

    skid_state_e          state_q, state_d;
    logic [c_res_w-1:0]   m_q, m_d;
    logic [c_res_w-1:0]   s_q, s_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    norm_rne_round #(
        .A_WIDTH   (A_WIDTH),
        .EXP_WIDTH (EXP_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_round (
        .i_b         (in_b),
        .i_exp       (in_exp),
        .i_no_detect (in_no_detect),
        .i_ovfl      (in_ovfl),
        .o_m         (w_rnd_m),
        .o_exp       (w_rnd_exp),
        .o_flags     (w_rnd_flags)
    );

    assign w_rnd_res = {w_rnd_m, w_rnd_exp, w_rnd_flags};

    // Both handshake flags come straight from the state register.
    assign out_valid = state_q[1];
    assign in_ready  = ~state_q[0];
    assign w_accept  = in_valid & in_ready;
    assign w_drain   = out_valid & out_ready;

    assign out_m       = m_q[c_res_w-1 -: OUT_WIDTH];
    assign out_exp     = m_q[EXP_WIDTH+2:3];
    assign w_out_flags = m_q[2:0];
    assign out_zero    = w_out_flags.zero;
    assign out_ovfl    = w_out_flags.ovfl;
    assign out_inexact = w_out_flags.inexact;
    assign inexact_cnt = cnt_q;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        case (state_q)
            ST_EMPTY: begin
                if (w_accept) begin
                    m_d     = w_rnd_res;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_accept && w_drain) begin
                    m_d = w_rnd_res;
                end else if (w_accept) begin
                    s_d     = w_rnd_res;
                    state_d = ST_FULL;
                end else if (w_drain) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_drain) begin
                    m_d     = s_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (w_accept && w_rnd_flags.inexact && !(&cnt_q)) begin
            cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            m_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule : norm_round_pipe
`default_nettype wire

// File: tb/tb_norm_round_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_norm_round_pipe: directed self-checking bench for norm_round_pipe |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_norm_round_pipe;

    localparam int A_WIDTH   = 8;
    localparam int EXP_WIDTH = 4;
    localparam int OUT_WIDTH = 5;
    localparam int CNT_WIDTH = 4;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [A_WIDTH-1:0]   in_b;
    logic [EXP_WIDTH-1:0] in_exp;
    logic                 in_no_detect;
    logic                 in_ovfl;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_m;
    logic [EXP_WIDTH-1:0] out_exp;
    logic                 out_zero;
    logic                 out_ovfl;
    logic                 out_inexact;
    logic                 cnt_clr;
    logic [CNT_WIDTH-1:0] inexact_cnt;

    int n_checks;
    int n_errors;

    norm_round_pipe #(
        .A_WIDTH   (A_WIDTH),
        .EXP_WIDTH (EXP_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_b         (in_b),
        .in_exp       (in_exp),
        .in_no_detect (in_no_detect),
        .in_ovfl      (in_ovfl),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_m        (out_m),
        .out_exp      (out_exp),
        .out_zero     (out_zero),
        .out_ovfl     (out_ovfl),
        .out_inexact  (out_inexact),
        .cnt_clr      (cnt_clr),
        .inexact_cnt  (inexact_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One beat with out_ready high; the result sits in M right after the edge.
    task automatic send_and_check(input string tag, input logic [7:0] b, input logic [3:0] e,
                                  input logic nd, input logic ov,
                                  input logic [4:0] xm, input logic [3:0] xe,
                                  input logic xz, input logic xo, input logic xi,
                                  input logic [3:0] xcnt);
        in_b = b; in_exp = e; in_no_detect = nd; in_ovfl = ov; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, ".valid"},   32'(out_valid),   32'd1);
        check({tag, ".m"},       32'(out_m),       32'(xm));
        check({tag, ".exp"},     32'(out_exp),     32'(xe));
        check({tag, ".zero"},    32'(out_zero),    32'(xz));
        check({tag, ".ovfl"},    32'(out_ovfl),    32'(xo));
        check({tag, ".inexact"}, 32'(out_inexact), 32'(xi));
        check({tag, ".cnt"},     32'(inexact_cnt), 32'(xcnt));
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_b = '0; in_exp = '0;
        in_no_detect = 1'b0; in_ovfl = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst.valid",   32'(out_valid),   32'd0);
        check("rst.ready",   32'(in_ready),    32'd1);
        check("rst.m",       32'(out_m),       32'd0);
        check("rst.exp",     32'(out_exp),     32'd0);
        check("rst.flags",   32'({out_zero, out_ovfl, out_inexact}), 32'd0);
        check("rst.cnt",     32'(inexact_cnt), 32'd0);

        //              tag          in_b          e     nd    ov    m          exp   z     o     ix    cnt
        send_and_check("tie_even",  8'b1011_0100, 4'd3, 1'b0, 1'b0, 5'b10110, 4'd3,  1'b0, 1'b0, 1'b1, 4'd1);
        send_and_check("tie_odd",   8'b1011_1100, 4'd3, 1'b0, 1'b0, 5'b11000, 4'd3,  1'b0, 1'b0, 1'b1, 4'd2);
        send_and_check("carry",     8'b1111_1100, 4'd3, 1'b0, 1'b0, 5'b10000, 4'd4,  1'b0, 1'b0, 1'b1, 4'd3);
        send_and_check("carry_max", 8'b1111_1100, 4'd15,1'b0, 1'b0, 5'b11111, 4'd15, 1'b0, 1'b1, 1'b1, 4'd4);
        send_and_check("nodet0",    8'b0000_0000, 4'd7, 1'b1, 1'b0, 5'b00000, 4'd0,  1'b1, 1'b0, 1'b0, 4'd4);
        send_and_check("nodet1",    8'b0000_0001, 4'd7, 1'b1, 1'b1, 5'b00000, 4'd0,  1'b1, 1'b0, 1'b1, 4'd5);
        send_and_check("exact",     8'b1010_1000, 4'd5, 1'b0, 1'b0, 5'b10101, 4'd5,  1'b0, 1'b0, 1'b0, 4'd5);
        send_and_check("in_ovfl",   8'b1010_1000, 4'd5, 1'b0, 1'b1, 5'b11111, 4'd15, 1'b0, 1'b1, 1'b0, 4'd5);
        send_and_check("sticky_up", 8'b1000_0101, 4'd2, 1'b0, 1'b0, 5'b10001, 4'd2,  1'b0, 1'b0, 1'b1, 4'd6);
        tick();
        check("drained.valid", 32'(out_valid), 32'd0);

        // Backpressure: A=10000, B=10001, C=10010, all exact.
        out_ready = 1'b0; in_exp = 4'd1; in_no_detect = 1'b0; in_ovfl = 1'b0;
        in_valid = 1'b1; in_b = 8'b1000_0000;
        tick();
        check("bp.a_ready", 32'(in_ready), 32'd1);
        check("bp.a_m",     32'(out_m),    32'h10);
        in_b = 8'b1000_1000;
        tick();
        check("bp.full_ready", 32'(in_ready), 32'd0);
        check("bp.full_m",     32'(out_m),    32'h10);
        in_b = 8'b1001_0000;
        tick();
        tick();
        check("bp.hold_valid", 32'(out_valid), 32'd1);
        check("bp.hold_m",     32'(out_m),     32'h10);
        check("bp.hold_ready", 32'(in_ready),  32'd0);
        out_ready = 1'b1;
        tick();
        check("bp.b_m",     32'(out_m),    32'h11);
        check("bp.b_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp.c_m",     32'(out_m),     32'h12);
        check("bp.c_valid", 32'(out_valid), 32'd1);
        tick();
        check("bp.empty", 32'(out_valid), 32'd0);
        check("bp.cnt",   32'(inexact_cnt), 32'd6);

        // Fill to FULL again, then an asynchronous reset between edges.
        out_ready = 1'b0; in_valid = 1'b1; in_b = 8'b1011_0100; in_exp = 4'd3;
        tick();
        tick();
        in_valid = 1'b0;
        check("pre_rst.ready", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.valid", 32'(out_valid),   32'd0);
        check("arst.ready", 32'(in_ready),    32'd1);
        check("arst.cnt",   32'(inexact_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Saturation: 15 inexact beats back to back, then one more.
        in_valid = 1'b1; in_b = 8'b1011_0100; in_exp = 4'd3;
        for (int i = 0; i < 15; i++) tick();
        check("sat.fill", 32'(inexact_cnt), 32'd15);
        check("sat.tput_ready", 32'(in_ready), 32'd1);
        tick();
        check("sat.hold", 32'(inexact_cnt), 32'd15);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        in_valid = 1'b0;
        check("sat.clr", 32'(inexact_cnt), 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule : tb_norm_round_pipe
`default_nettype wire

// File: doc/norm_round_pipe.md
# norm_round_pipe

Rounding and packing stage placed directly downstream of the DW_norm normalizer. It takes the normalized mantissa, adjusted exponent and flags from DW_norm, rounds the mantissa to a narrower width with round-to-nearest-even, and applies post-rounding exponent increment with saturation. Results are registered behind a valid/ready handshake with a one-entry skid buffer, so the block sustains one result per cycle under backpressure. A saturating counter tracks inexact results for debug.

## Interface
- a_width, 8: normalized mantissa width from the normalizer (≥ out_width+2).
- exp_width, 4: exponent width.
- out_width, 5: rounded mantissa width.
- cnt_width, 16: inexact-counter width.

- clk  in  1  clock, rising edge.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_b  in  a_width  normalized mantissa (DW_norm b).
- in_exp  in  exp_width  adjusted exponent (DW_norm exp_adj).
- in_no_detect  in  1  DW_norm no_detect.
- in_ovfl  in  1  DW_norm ovfl.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_m  out  out_width  rounded mantissa.
- out_exp  out  exp_width  result exponent.
- out_zero  out  1  result is zero.
- out_ovfl  out  1  exponent overflow (input or rounding).
- out_inexact  out  1  discarded bits were nonzero.
- cnt_clr  in  1  synchronous clear of inexact counter.
- inexact_cnt  out  cnt_width  saturating count of accepted inexact results.

## Operation
- Accept on in_valid & in_ready; deliver on out_valid & out_ready.
- Mantissa split: kept = in_b[a_width-1 -: out_width]; guard = next bit below; sticky = OR of all remaining lower bits; lsb = kept[0].
- inexact = guard | sticky.
- Round up iff guard & (sticky | lsb).
- Round-up carry out of kept (kept all ones): m = 1 followed by zeros, exp = in_exp+1.
- If that increment would wrap (in_exp all ones), or in_ovfl=1: out_ovfl=1, m = all ones, exp = all ones.
- in_no_detect=1 overrides everything: m=0, exp=0, zero=1, ovfl=0, inexact = |in_b.
- Otherwise zero=0.
- Counter: increments by 1 on each accepted beat with inexact=1; saturates at all ones; cnt_clr has priority over an increment in the same cycle, giving 0.
- Storage: main output register (M) plus skid register (S).
  - Accept while M empty or M drains this cycle: result goes to M.
  - Accept while M holds and is stalled: result goes to S.
  - When M drains and S is full: S moves to M.
  - in_ready = !S_valid (registered).
- States, from {M_valid,S_valid}: EMPTY(00), ONE(10), FULL(11). State 01 never occurs.
  - EMPTY→ONE on accept.
  - ONE→FULL on accept without drain.
  - ONE→EMPTY on drain without accept.
  - FULL→ONE on drain (no accept possible).

## Timing
- Latency: beat accepted at edge n is presented on out_valid/out_* after edge n; no combinational in→out path.
- out_ready→in_ready: registered. In FULL, in_ready rises one cycle after the drain.
- Throughput: 1 beat/cycle with out_ready held high.
- out_* hold stable while out_valid & !out_ready.
- Beats are delivered strictly in order.
- Reset (async assert, sync release) values: out_valid=0, in_ready=1, out_m=0, out_exp=0, out_zero=0, out_ovfl=0, out_inexact=0, inexact_cnt=0.
- Reset mid-operation discards M and S contents.
- Simultaneous accept and drain in ONE: stays ONE, M takes the new beat.

## Structure
- Shared package norm_pkg: round_mode enum (only RNE used here), flag bundle struct {zero, ovfl, inexact}, exponent saturation constant.
- Sub-module norm_rne_round: purely combinational kept/guard/sticky/increment/saturate logic, instantiated once ahead of M/S.
- Handshake, skid and counter logic live in the top.

## Test plan
All scenarios use defaults (a=8, out=5, exp=4), out_ready=1 unless stated.
- Tie, even LSB: in_b=1011_0100, exp=3 → m=10110, exp=3, inexact=1, cnt=1.
- Tie, odd LSB: in_b=1011_1100, exp=3 → m=11000, exp=3, inexact=1.
- Carry: in_b=1111_1100, exp=3 → m=10000, exp=4.
- Carry at max exponent: same in_b with exp=15 → ovfl=1, m=11111, exp=15.
- No detect: in_no_detect=1, in_b=0 → zero=1, m=0, exp=0, inexact=0.
- Backpressure:
  - out_ready=0 for 4 cycles with in_valid=1 and beats A,B,C → A,B accepted, in_ready=0 from cycle 2.
  - Raise out_ready → A,B,C delivered in order, no loss or duplication.
- Reset mid-FULL:
  - rst_n low for 1 cycle → out_valid=0, in_ready=1, inexact_cnt=0 immediately.
  - Counter at all ones plus another inexact beat → stays all ones; cnt_clr in the same cycle → 0.
